simmem_iid_allocator: RTL



---
 rtl/simmem_pkg.sv | 27 ++
 rtl/simmem_rr_free_finder.sv | 27 ++
 rtl/simmem_iid_allocator.sv | 119 +++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared types, capacities and bit-counting helpers for the simmem IID allocators.
// The write-side and read-side allocator instances both use this package.
package simmem_pkg;

    localparam int unsigned WriteRespBankCapacity = 8;
    localparam int unsigned ReadDataBankCapacity  = 8;

    // Widest onehot vector the helpers accept. Every allocator capacity must be no larger than this.
    localparam int unsigned MaxCapacity = 64;

    typedef logic [$clog2(WriteRespBankCapacity)-1:0] write_iid_t;
    typedef logic [$clog2(ReadDataBankCapacity)-1:0]  read_iid_t;

    function automatic int unsigned popcount(input logic [MaxCapacity-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MaxCapacity); i++) begin
            n += int'(vec[i]);
        end
        return n;
    endfunction

    function automatic logic is_onehot(input logic [MaxCapacity-1:0] vec);
        return popcount(vec) == 1;
    endfunction

endpackage

// File: rtl/simmem_rr_free_finder.sv
// Rotated priority encoder. It returns the first set bit of free_i found by
// searching upward from start_i and wrapping modulo Capacity.
module simmem_rr_free_finder #(
    parameter int unsigned Capacity = 4,
    parameter int unsigned IidWidth = $clog2(Capacity)
) (
    input  logic [Capacity-1:0] free_i,
    input  logic [IidWidth-1:0] start_i,
    output logic [IidWidth-1:0] idx_o,
    output logic                any_free_o
);

    always_comb begin
        int cand;
        // NOTE: defaults come first so every path assigns idx_o and no latch is inferred.
        idx_o      = '0;
        any_free_o = |free_i;
        // Walk the offsets from farthest to nearest, so the nearest free slot is written last and wins.
        for (int i = int'(Capacity) - 1; i >= 0; i--) begin
            cand = (int'(start_i) + i) % int'(Capacity);
            if (free_i[cand]) begin
                idx_o = IidWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/simmem_iid_allocator.sv
// IID allocator: offers a free slot with each write address and reclaims slots on release.
// Define SIMMEM_IID_ALLOC_ROUND_ROBIN_EN for rotating search; otherwise the lowest free IID is used.
module simmem_iid_allocator
    import simmem_pkg::*;
#(
    parameter int unsigned Capacity = simmem_pkg::WriteRespBankCapacity,
    parameter int unsigned IidWidth = $clog2(Capacity)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           addr_valid_i,
    output logic                           addr_ready_o,
    output logic                           dn_valid_o,
    input  logic                           dn_ready_i,
    output logic [IidWidth-1:0]            iid_o,
    input  logic [Capacity-1:0]            released_addr_onehot_i,
    output logic [$clog2(Capacity+1)-1:0]  occupancy_o,
    output logic                           full_o,
    output logic                           error_o
);

    localparam int unsigned CntWidth = $clog2(Capacity + 1);

    logic [Capacity-1:0] free_q, free_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [IidWidth-1:0] search_start;
    logic [IidWidth-1:0] free_idx;
    logic                any_free;
    logic                alloc;
    logic                rel_single;
    logic                rel_hits_busy;
    logic                rel_ok;
    int unsigned         rel_cnt;

`ifdef SIMMEM_IID_ALLOC_ROUND_ROBIN_EN
    logic [IidWidth-1:0] ptr_q, ptr_d;
    assign search_start = ptr_q;
`else
    assign search_start = '0;
`endif

    simmem_rr_free_finder #(
        .Capacity (Capacity),
        .IidWidth (IidWidth)
    ) u_free_finder (
        .free_i     (free_q),
        .start_i    (search_start),
        .idx_o      (free_idx),
        .any_free_o (any_free)
    );

    assign dn_valid_o   = addr_valid_i & any_free;
    assign addr_ready_o = dn_ready_i & any_free;
    assign iid_o        = free_idx;
    assign full_o       = ~any_free;
    assign occupancy_o  = cnt_q;
    assign error_o      = err_q;

    always_comb begin
        alloc         = addr_valid_i & dn_ready_i & any_free;
        rel_cnt       = popcount(MaxCapacity'(released_addr_onehot_i));
        rel_single    = (rel_cnt == 1);
        rel_hits_busy = |(released_addr_onehot_i & ~free_q);
        rel_ok        = rel_single & rel_hits_busy;

        free_d = free_q;
        cnt_d  = cnt_q;
        err_d  = err_q;

        // An allocation and a valid release never hit the same slot: one targets a free slot, the other a busy one.
        if (alloc) begin
            free_d[free_idx] = 1'b0;
        end
        if (rel_ok) begin
            free_d = free_d | released_addr_onehot_i;
        end
        if ((rel_cnt > 1) || (rel_single && !rel_hits_busy)) begin
            err_d = 1'b1;
        end

        unique case ({alloc, rel_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef SIMMEM_IID_ALLOC_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (alloc) begin
            ptr_d = (free_idx == IidWidth'(Capacity - 1)) ? '0 : free_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only; the free map is a flop vector and resets to all-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q <= '1;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule
